// File: rtl/nes_pkg.sv
// Shared types and constants for the dual NES controller poller.
package nes_pkg;

  // Number of buttons shifted out of one 4021-based controller.
  localparam int NES_BITS = 8;

  // Bit positions of each button in the buttons_p* vectors.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : nes_pkg

// File: rtl/nes_bit_sync.sv
// Two-flop synchronizer for one asynchronous controller data pin.
module nes_bit_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw pin through two flops to settle metastability.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : nes_bit_sync

// File: rtl/nes_dual_poller.sv
// Serial poller for two NES controllers: drives latch/clock, shifts in
// eight active-low button bits per pad and presents registered,
// active-high button vectors with a one-cycle valid strobe.
module nes_dual_poller
  import nes_pkg::*;
#(
  // clk cycles per protocol half-period; must be at least 4 so that data
  // changed on a rising clk_p* edge has settled through the synchronizer
  // well before the end of the following LOW phase.
  parameter int HALF_CYCLES      = 151,
  // Auto-poll interval in clk cycles; 0 disables the internal timer.
  parameter int AUTO_POLL_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                poll_req,
  input  logic                data_p1,
  input  logic                data_p2,
  output logic                latch_p1,
  output logic                clk_p1,
  output logic                latch_p2,
  output logic                clk_p2,
  output logic [NES_BITS-1:0] buttons_p1,
  output logic [NES_BITS-1:0] buttons_p2,
  output logic                buttons_valid,
  output logic                busy
);

  // The phase counter must reach 2*HALF_CYCLES-1 (the LATCH phase).
  localparam int CNT_W = $clog2(2 * HALF_CYCLES);
  localparam int IDX_W = $clog2(NES_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NES_BITS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NES_BITS-1:0] sr1_q, sr1_d;
  logic [NES_BITS-1:0] sr2_q, sr2_d;
  logic [NES_BITS-1:0] btn1_q, btn1_d;
  logic [NES_BITS-1:0] btn2_q, btn2_d;
  logic                latch_q, latch_d;
  logic                sclk_q, sclk_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  logic                sync_p1;
  logic                sync_p2;
  logic                auto_tick;
  logic                start;

  // ---------------------------------------------------------------------
  // Input synchronizers, one per controller data pin.
  // ---------------------------------------------------------------------
  nes_bit_sync u_sync_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (data_p1),
    .sync_o  (sync_p1)
  );

  nes_bit_sync u_sync_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (data_p2),
    .sync_o  (sync_p2)
  );

  // ---------------------------------------------------------------------
  // Optional free-running auto-poll timer, counted from reset release.
  // ---------------------------------------------------------------------
  if (AUTO_POLL_CYCLES > 0) begin : g_auto
    localparam int AP_W = (AUTO_POLL_CYCLES > 1) ? $clog2(AUTO_POLL_CYCLES) : 1;
    localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_POLL_CYCLES - 1);

    logic [AP_W-1:0] ap_cnt_q;

    // Wrap the interval counter every AUTO_POLL_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ap_cnt_q <= '0;
      end else if (ap_cnt_q == AP_LAST) begin
        ap_cnt_q <= '0;
      end else begin
        ap_cnt_q <= ap_cnt_q + AP_W'(1);
      end
    end

    assign auto_tick = (ap_cnt_q == AP_LAST);
  end else begin : g_no_auto
    assign auto_tick = 1'b0;
  end

  // A request and a tick in the same cycle collapse into one scan; both
  // are ignored outside IDLE, so nothing is queued while busy.
  assign start = poll_req | auto_tick;

  // ---------------------------------------------------------------------
  // Scan sequencer: next state, phase counter, bit index, shift registers.
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_LOW: begin
        if (cnt_q == HALF_LAST) begin
          // Pins are active-low: a pressed button drives the line low.
          sr1_d[idx_q] = ~sync_p1;
          sr2_d[idx_q] = ~sync_p2;
          cnt_d        = '0;
          state_d      = (idx_q == IDX_LAST) ? ST_DONE : ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so pin edges line
  // up exactly with state transitions and never glitch.
  always_comb begin
    latch_d = (state_d == ST_LATCH);
    sclk_d  = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_q == ST_DONE);
    btn1_d  = (state_q == ST_DONE) ? sr1_q : btn1_q;
    btn2_d  = (state_q == ST_DONE) ? sr2_q : btn2_q;
  end

  // State, datapath and output registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      btn1_q  <= '0;
      btn2_q  <= '0;
      latch_q <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      latch_q <= latch_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Both controllers share one timing generator.
  assign latch_p1      = latch_q;
  assign latch_p2      = latch_q;
  assign clk_p1        = sclk_q;
  assign clk_p2        = sclk_q;
  assign buttons_p1    = btn1_q;
  assign buttons_p2    = btn2_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;

endmodule : nes_dual_poller

// File: doc/nes_dual_poller.md
Name: nes_dual_poller

Overview:
Sequences the serial read of two NES controllers (4021 shift registers) for the Pong game. It drives separate latch/clock pins per controller and shifts in 8 button bits from each data pin. It presents registered, active-high button vectors to the game logic with a one-cycle valid strobe. Polls start from an external request (e.g. once per frame at vsync) or from an optional internal auto-poll timer.

Parameters:
HALF_CYCLES, 151, clk cycles per protocol half-period (~6 us at 25.175 MHz); minimum 4
AUTO_POLL_CYCLES, 0, auto-poll interval in clk cycles; 0 disables the timer

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
poll_req  in  1  single-cycle request to start a scan
data_p1  in  1  serial data from controller 1, active-low, asynchronous
data_p2  in  1  serial data from controller 2, active-low, asynchronous
latch_p1  out  1  latch to controller 1
clk_p1  out  1  shift clock to controller 1
latch_p2  out  1  latch to controller 2 (identical timing to latch_p1)
clk_p2  out  1  shift clock to controller 2 (identical timing to clk_p1)
buttons_p1  out  8  controller 1 buttons, 1 = pressed
buttons_p2  out  8  controller 2 buttons, 1 = pressed
buttons_valid  out  1  one-cycle strobe when buttons_* update
busy  out  1  high while a scan is in progress

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM to IDLE; half-period counter, bit index, shift registers, synchronizers and auto-poll timer cleared. Reset mid-scan aborts the scan; the scan is not resumed.
- data_p1/data_p2 each pass through a 2-flop synchronizer before use.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. All pin outputs are registered.
- IDLE: start condition = poll_req | auto_tick. On the start edge, go to LATCH and set busy=1.
- LATCH: latch_p*=1 for exactly 2*HALF_CYCLES cycles, then go to LOW with bit index 0.
- LOW: latch and clk both low for HALF_CYCLES cycles. On the last cycle, sample the synchronized data into bit[index] of each shift register as ~data (inverted, because the pins are active-low).
  - index<7: go to HIGH.
  - index==7: go to DONE.
- HIGH: clk_p*=1 for HALF_CYCLES cycles; index+1; back to LOW.
- Pulse counts per scan: 1 latch pulse and exactly 7 clock pulses.
- DONE (1 cycle): load buttons_p1/p2 from the shift registers, assert buttons_valid for one cycle, clear busy, go to IDLE.
- Latency: buttons_valid is high in the cycle 17*HALF_CYCLES+1 cycles after the edge that sampled the start condition. With HALF_CYCLES=4 this is 69.
- Bit map: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6Left, 7 Right.
- Data must be stable for at least 3 cycles before the end of each LOW phase. HALF_CYCLES>=4 guarantees this when a controller changes data on the rising edge of clk_p*.
- A start condition while busy is dropped, not queued. buttons_* hold their last value between scans.
- Disconnected controller (pin pulled high) reads as buttons=0x00.
- Auto-poll: when AUTO_POLL_CYCLES>0, a free-running counter pulses auto_tick every AUTO_POLL_CYCLES cycles, counted from reset release. A tick that lands while busy is dropped. poll_req and auto_tick arriving together start a single scan.
- Counter widths are derived with $clog2 from the parameters; no wrap ambiguity.

Decomposition:
- nes_pkg holds:
  - the FSM state enum;
  - button index constants BTN_A..BTN_RIGHT;
  - NES_BITS=8.
- One sub-module, nes_bit_sync: a 2-flop synchronizer with async active-low reset. Instantiate it once per data pin.

Test Plan:
- Reset state: reset_n=0 held 5 cycles, then released -> all outputs 0; busy=0; no activity on latch_p*/clk_p* for 100 cycles (HALF_CYCLES=4, AUTO_POLL_CYCLES=0).
- Basic scan: pulse poll_req. Controller 1 model presses A and Start (bit0 and bit3 driven low); controller 2 idle (high). Required: buttons_valid exactly 69 cycles after poll_req; buttons_p1=0x09; buttons_p2=0x00; busy falls in the same cycle.
- Pin timing: measure latch_p1 high for 8 cycles; clk_p1 shows 7 high pulses of 4 cycles, each with 4-cycle low gaps; p2 pins identical to p1. Patterns 0xA5 on p1 and 0x5A on p2 (pressed=1) -> buttons_p1=0xA5, buttons_p2=0x5A.
- Busy drop: second poll_req 20 cycles into a scan -> exactly one buttons_valid. A new poll_req after valid starts a fresh scan -> second valid.
- Auto-poll: AUTO_POLL_CYCLES=200, poll_req tied low -> buttons_valid every 200 cycles. poll_req coincident with a tick -> one scan.
- Reset mid-scan: assert reset_n=0 at cycle 30 of a scan -> latch/clk/busy/buttons go to 0 immediately. After release, a new poll completes normally with correct values.
